// File: rtl/mem_sequencer.sv
// Byte-wide memory sequencer: arbitrates CPU and loader requests and walks the
// MAR/MDR/RAM strobe sequence for byte and big-endian 16-bit transfers.
module mem_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_wide,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        cpu_gnt,
    output logic        ld_gnt,
    output logic        cpu_done,
    output logic        ld_done,
    input  logic [15:0] mem_out,
    output logic [15:0] rd_data,
    output logic        mar_loadh,
    output logic        mar_loadl,
    output logic        mdr_load,
    output logic        ram_load,
    output logic        ram_enh,
    output logic        ram_enl,
    output logic [15:0] bus_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR, S_RDH, S_RDL, S_DONE
    } state_t;

    state_t      r_state;
    logic        r_phase;
    logic        r_owner_ld;
    logic        r_last_ld;
    logic        r_we;
    logic        r_wide;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    state_t      w_nxt_state;
    logic        w_nxt_phase;
    logic        w_nxt_owner_ld;
    logic        w_nxt_last_ld;
    logic        w_nxt_we;
    logic        w_nxt_wide;
    logic [15:0] w_nxt_addr;
    logic [15:0] w_nxt_wdata;
    logic        w_pick_ld;

    logic        w_cpu_gnt;
    logic        w_ld_gnt;
    logic        w_cpu_done;
    logic        w_ld_done;
    logic        w_mar_load;
    logic        w_mdr_load;
    logic        w_ram_load;
    logic        w_ram_enh;
    logic        w_ram_enl;
    logic [15:0] w_bus;

    // Round robin: loader wins a tie unless it was the last one served.
    assign w_pick_ld = ld_req & (~cpu_req | ~r_last_ld);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_phase    = r_phase;
        w_nxt_owner_ld = r_owner_ld;
        w_nxt_last_ld  = r_last_ld;
        w_nxt_we       = r_we;
        w_nxt_wide     = r_wide;
        w_nxt_addr     = r_addr;
        w_nxt_wdata    = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (cpu_req | ld_req) begin
                    w_nxt_state    = S_ADDR;
                    w_nxt_phase    = 1'b0;
                    w_nxt_owner_ld = w_pick_ld;
                    w_nxt_last_ld  = w_pick_ld;
                    if (w_pick_ld) begin
                        w_nxt_we    = 1'b1;
                        w_nxt_wide  = 1'b0;
                        w_nxt_addr  = ld_addr;
                        w_nxt_wdata = {8'h00, ld_wdata};
                    end else begin
                        w_nxt_we    = cpu_we;
                        w_nxt_wide  = cpu_wide;
                        w_nxt_addr  = cpu_addr;
                        w_nxt_wdata = cpu_wdata;
                    end
                end
            end
            S_ADDR: begin
                if (r_we)
                    w_nxt_state = S_DATA;
                else if (r_wide & ~r_phase)
                    w_nxt_state = S_RDH;
                else
                    w_nxt_state = S_RDL;
            end
            S_DATA: w_nxt_state = S_WR;
            S_WR: begin
                if (r_wide & ~r_phase) begin
                    w_nxt_state = S_ADDR;
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_state = S_DONE;
                end
            end
            S_RDH: begin
                w_nxt_state = S_ADDR;
                w_nxt_phase = 1'b1;
            end
            S_RDL:   w_nxt_state = S_DONE;
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_mar_load = 1'b0;
        w_mdr_load = 1'b0;
        w_ram_load = 1'b0;
        w_ram_enh  = 1'b0;
        w_ram_enl  = 1'b0;
        w_bus      = 16'h0000;
        case (w_nxt_state)
            S_ADDR: begin
                w_mar_load = 1'b1;
                w_bus      = w_nxt_addr + {15'd0, w_nxt_phase};
            end
            S_DATA: begin
                w_mdr_load = 1'b1;
                w_bus      = {8'h00, (w_nxt_wide & ~w_nxt_phase) ? w_nxt_wdata[15:8]
                                                                 : w_nxt_wdata[7:0]};
            end
            S_WR:    w_ram_load = 1'b1;
            S_RDH:   w_ram_enh  = 1'b1;
            S_RDL:   w_ram_enl  = 1'b1;
            default: ;
        endcase
        w_ld_gnt   = (w_nxt_state != S_IDLE) &  w_nxt_owner_ld;
        w_cpu_gnt  = (w_nxt_state != S_IDLE) & ~w_nxt_owner_ld;
        w_ld_done  = (w_nxt_state == S_DONE) &  w_nxt_owner_ld;
        w_cpu_done = (w_nxt_state == S_DONE) & ~w_nxt_owner_ld;
    end

    always_ff @(posedge clk) begin
        r_addr  <= w_nxt_addr;
        r_wdata <= w_nxt_wdata;
        if (rst) begin
            r_state    <= S_IDLE;
            r_phase    <= 1'b0;
            r_owner_ld <= 1'b0;
            r_last_ld  <= 1'b0;
            r_we       <= 1'b0;
            r_wide     <= 1'b0;
            cpu_gnt    <= 1'b0;
            ld_gnt     <= 1'b0;
            cpu_done   <= 1'b0;
            ld_done    <= 1'b0;
            mar_loadh  <= 1'b0;
            mar_loadl  <= 1'b0;
            mdr_load   <= 1'b0;
            ram_load   <= 1'b0;
            ram_enh    <= 1'b0;
            ram_enl    <= 1'b0;
            bus_out    <= 16'h0000;
        end else begin
            r_state    <= w_nxt_state;
            r_phase    <= w_nxt_phase;
            r_owner_ld <= w_nxt_owner_ld;
            r_last_ld  <= w_nxt_last_ld;
            r_we       <= w_nxt_we;
            r_wide     <= w_nxt_wide;
            cpu_gnt    <= w_cpu_gnt;
            ld_gnt     <= w_ld_gnt;
            cpu_done   <= w_cpu_done;
            ld_done    <= w_ld_done;
            mar_loadh  <= w_mar_load;
            mar_loadl  <= w_mar_load;
            mdr_load   <= w_mdr_load;
            ram_load   <= w_ram_load;
            ram_enh    <= w_ram_enh;
            ram_enl    <= w_ram_enl;
            bus_out    <= w_bus;
        end
    end

    assign rd_data = mem_out;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: a 64-byte MAR/MDR memory, a transaction-level
// reference model producing expected per-cycle outputs, directed and random runs.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_wide, ld_req;
    logic [15:0] cpu_addr, cpu_wdata, ld_addr;
    logic [7:0]  ld_wdata;
    logic        cpu_gnt, ld_gnt, cpu_done, ld_done;
    logic [15:0] mem_out, rd_data, bus_out;
    logic        mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl;

    always #5 clk = ~clk;

    mem_sequencer dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wide(cpu_wide),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .cpu_gnt(cpu_gnt), .ld_gnt(ld_gnt), .cpu_done(cpu_done), .ld_done(ld_done),
        .mem_out(mem_out), .rd_data(rd_data),
        .mar_loadh(mar_loadh), .mar_loadl(mar_loadl), .mdr_load(mdr_load),
        .ram_load(ram_load), .ram_enh(ram_enh), .ram_enl(ram_enl),
        .bus_out(bus_out)
    );

    // Memory peripheral driven by the strobes; decodes the low 6 address bits.
    logic [7:0]  ram [64];
    logic [15:0] mar, mdr;
    always @(posedge clk) begin
        if (mar_loadh) mar[15:8] <= bus_out[15:8];
        if (mar_loadl) mar[7:0]  <= bus_out[7:0];
        if (mdr_load)  mdr       <= bus_out;
        if (ram_load)  ram[mar[5:0]] <= mdr[7:0];
        if (ram_enh)   mdr[15:8] <= ram[mar[5:0]];
        if (ram_enl)   mdr[7:0]  <= ram[mar[5:0]];
    end
    assign mem_out = mdr;

    // Reference model: each granted transaction expands into its list of bus cycles.
    typedef struct {
        logic [1:0]  gnt;    // {cpu, ld}
        logic [1:0]  done;   // {cpu, ld}
        logic [5:0]  stb;    // {mar_h, mar_l, mdr_load, ram_load, ram_enh, ram_enl}
        logic [15:0] bus;
        bit          wr;
        logic [5:0]  waddr;
        logic [7:0]  wdat;
        bit          rd;
        bit          rdwide;
        logic [15:0] raddr;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mm [64];
    int          own;        // 0 none, 1 loader, 2 cpu
    bit          last_ld;
    bit          cur_idle;
    logic [1:0]  last_done;
    int          checks;
    int          errors;

    function automatic exp_t mk(logic [1:0] g, logic [5:0] s, logic [15:0] b);
        exp_t e;
        e.gnt = g; e.done = 2'b00; e.stb = s; e.bus = b;
        e.wr = 0; e.waddr = 6'd0; e.wdat = 8'd0;
        e.rd = 0; e.rdwide = 0; e.raddr = 16'd0;
        return e;
    endfunction

    task automatic push_txn(input bit is_ld, input bit we, input bit wide,
                            input logic [15:0] addr, input logic [15:0] wdata);
        exp_t        e;
        logic [1:0]  g;
        logic [15:0] a;
        logic [7:0]  b;
        g = is_ld ? 2'b01 : 2'b10;
        for (int i = 0; i < (wide ? 2 : 1); i++) begin
            a = addr + 16'(i);
            b = (wide && i == 0) ? wdata[15:8] : wdata[7:0];
            q.push_back(mk(g, 6'b110000, a));
            if (we) begin
                q.push_back(mk(g, 6'b001000, {8'h00, b}));
                e = mk(g, 6'b000100, 16'h0000);
                e.wr = 1; e.waddr = a[5:0]; e.wdat = b;
                q.push_back(e);
            end else begin
                q.push_back(mk(g, (wide && i == 0) ? 6'b000010 : 6'b000001, 16'h0000));
            end
        end
        e = mk(g, 6'b000000, 16'h0000);
        e.done = g; e.rd = !we; e.rdwide = wide; e.raddr = addr;
        q.push_back(e);
    endtask

    task automatic model_commit();
        bit pick_ld;
        if (rst) begin
            q.delete();
            own = 0;
            last_ld = 0;
        end else if (cur_idle && (ld_req || cpu_req)) begin
            pick_ld = ld_req && (!cpu_req || !last_ld);
            last_ld = pick_ld;
            own = pick_ld ? 1 : 2;
            if (pick_ld) push_txn(1, 1, 0, ld_addr, {8'h00, ld_wdata});
            else         push_txn(0, cpu_we, cpu_wide, cpu_addr, cpu_wdata);
        end
    endtask

    task automatic check_outputs();
        exp_t        e;
        logic [25:0] act, exp;
        logic [15:0] a1, erd, mask;
        cur_idle = (q.size() == 0);
        e = cur_idle ? mk(2'b00, 6'b000000, 16'h0000) : q.pop_front();
        act = {cpu_gnt, ld_gnt, cpu_done, ld_done, mar_loadh, mar_loadl,
               mdr_load, ram_load, ram_enh, ram_enl, bus_out};
        exp = {e.gnt, e.done, e.stb, e.bus};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got gnt=%b done=%b stb=%b bus=%h want gnt=%b done=%b stb=%b bus=%h",
                     $time, act[25:24], act[23:22], act[21:16], act[15:0],
                     exp[25:24], exp[23:22], exp[21:16], exp[15:0]);
        end
        checks++;
        if ($countones({mdr_load, ram_load, ram_enh, ram_enl}) > 1) begin
            errors++;
            $display("FAIL strobe_onehot t=%0t got %b want at most one set", $time,
                     {mdr_load, ram_load, ram_enh, ram_enl});
        end
        checks++;
        if (cpu_gnt && ld_gnt) begin
            errors++;
            $display("FAIL gnt_excl t=%0t got cpu_gnt=1 ld_gnt=1 want not both", $time);
        end
        if (e.wr) mm[e.waddr] = e.wdat;
        if (e.rd) begin
            a1   = e.raddr + 16'd1;
            erd  = e.rdwide ? {mm[e.raddr[5:0]], mm[a1[5:0]]} : {8'h00, mm[e.raddr[5:0]]};
            mask = e.rdwide ? 16'hFFFF : 16'h00FF;
            checks++;
            if ((rd_data & mask) !== erd) begin
                errors++;
                $display("FAIL rd_data t=%0t got %h want %h", $time, rd_data & mask, erd);
            end
        end
        if (e.done != 2'b00) own = 0;
        last_done = e.done;
    endtask

    task automatic cycle();
        model_commit();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_to_done(input bit is_ld, input int maxc, output int lat);
        lat = 0;
        forever begin
            cycle();
            lat++;
            if (is_ld ? ld_done : cpu_done) break;
            if (lat >= maxc) break;
        end
        if (is_ld) ld_req = 0; else cpu_req = 0;
    endtask

    task automatic cpu_start(input bit we, input bit wide, input logic [15:0] a,
                             input logic [15:0] d);
        cpu_req = 1; cpu_we = we; cpu_wide = wide; cpu_addr = a; cpu_wdata = d;
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 16'hFFFF;
        if (r == 1) return {10'($urandom), 6'h3F};
        return 16'($urandom);
    endfunction

    int         lat;
    int         nd;
    logic [1:0] seq [4];
    bit         ld_pend, cpu_pend;

    initial begin
        checks = 0; errors = 0; own = 0; last_ld = 0; cur_idle = 1; last_done = 2'b00;
        mar = 16'h0000; mdr = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 8'($urandom);
            mm[i]  = ram[i];
        end
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_wide = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_addr = 0; ld_wdata = 0;
        cycle(); cycle();
        pin("reset_outputs", {6'd0, cpu_gnt, ld_gnt, cpu_done, ld_done, mar_loadh, mar_loadl,
            mdr_load, ram_load, ram_enh, ram_enl, bus_out}, 32'h0);
        rst = 0;
        cycle();

        // Loader byte write with per-cycle literal expectations.
        ld_req = 1; ld_addr = 16'h0005; ld_wdata = 8'hA5;
        cycle();
        pin("ld_addr_cycle", {14'd0, mar_loadh, mar_loadl, bus_out}, {14'd0, 2'b11, 16'h0005});
        ld_addr = 16'h0033; ld_wdata = 8'h11;
        cycle();
        pin("ld_data_cycle", {15'd0, mdr_load, bus_out}, {15'd0, 1'b1, 16'h00A5});
        cycle();
        pin("ld_wr_cycle", {31'd0, ram_load}, 32'd1);
        cycle();
        pin("ld_done_cycle4", {30'd0, ld_done, ld_gnt}, 32'd3);
        ld_req = 0;
        cycle();

        // CPU wide write then reads of the same address.
        cpu_start(1, 1, 16'h0010, 16'h1234);
        run_to_done(0, 30, lat);
        pin("wide_write_lat", lat, 7);
        cycle();
        cpu_start(0, 1, 16'h0010, 16'h0000);
        run_to_done(0, 30, lat);
        pin("wide_read_lat", lat, 5);
        pin("wide_read_data", {16'd0, rd_data}, 32'h1234);
        cycle();
        cpu_start(0, 0, 16'h0010, 16'h0000);
        run_to_done(0, 30, lat);
        pin("byte_read_lat", lat, 3);
        pin("byte_read_data", {24'd0, rd_data[7:0]}, 32'h12);
        cycle();
        cpu_start(1, 0, 16'h0011, 16'hFFC3);
        run_to_done(0, 30, lat);
        pin("byte_write_lat", lat, 4);
        cycle();
        cpu_start(0, 1, 16'h0010, 16'h0000);
        run_to_done(0, 30, lat);
        pin("byte_merge_read", {16'd0, rd_data}, 32'h12C3);
        cycle();

        // Wide access at the top of the address space wraps to 0.
        cpu_start(1, 1, 16'hFFFF, 16'hABCD);
        run_to_done(0, 30, lat);
        cycle();
        cpu_start(0, 1, 16'hFFFF, 16'h0000);
        cycle();
        pin("wrap_first_addr", {16'd0, bus_out}, 32'hFFFF);
        cycle();
        cycle();
        pin("wrap_second_addr", {14'd0, mar_loadh, mar_loadl, bus_out}, {14'd0, 2'b11, 16'h0000});
        run_to_done(0, 30, lat);
        pin("wrap_read_data", {16'd0, rd_data}, 32'hABCD);
        cycle();

        // Reset during the first WR of a wide write.
        cpu_start(1, 1, 16'h0020, 16'hBEEF);
        cycle(); cycle(); cycle();
        pin("abort_in_wr", {31'd0, ram_load}, 32'd1);
        rst = 1;
        cycle();
        pin("abort_outputs", {6'd0, cpu_gnt, ld_gnt, cpu_done, ld_done, mar_loadh, mar_loadl,
            mdr_load, ram_load, ram_enh, ram_enl, bus_out}, 32'h0);
        rst = 0; cpu_req = 0;
        cycle();
        ld_req = 1; ld_addr = 16'h0021; ld_wdata = 8'h77;
        run_to_done(1, 30, lat);
        pin("after_abort_lat", lat, 4);
        cycle();
        cpu_start(0, 0, 16'h0020, 16'h0000);
        run_to_done(0, 30, lat);
        pin("partial_write_kept", {24'd0, rd_data[7:0]}, 32'hBE);
        cycle();

        // Both requesters held from reset release alternate, loader first.
        rst = 1;
        cpu_start(0, 0, 16'h0008, 16'h0000);
        ld_req = 1; ld_addr = 16'h0009; ld_wdata = 8'h5A;
        cycle(); cycle();
        rst = 0;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            cycle();
            if (ld_done) begin seq[nd] = 2'd1; nd++; end
            else if (cpu_done) begin seq[nd] = 2'd2; nd++; end
        end
        ld_req = 0; cpu_req = 0;
        pin("rr_count", nd, 4);
        pin("rr_order", {24'd0, seq[0], seq[1], seq[2], seq[3]}, {24'd0, 8'b01_10_01_10});
        cycle();

        // Randomized traffic with address/data scrambling and occasional resets.
        ld_pend = 0; cpu_pend = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1; ld_req = 0; cpu_req = 0; ld_pend = 0; cpu_pend = 0;
            end else begin
                rst = 0;
                if (last_done[0]) begin
                    ld_pend = 0; ld_req = 0;
                end else if (ld_pend && own == 1) begin
                    ld_addr = 16'($urandom); ld_wdata = 8'($urandom); ld_req = 1'($urandom);
                end else if (!ld_pend && $urandom_range(0, 2) == 0) begin
                    ld_pend = 1; ld_req = 1; ld_addr = rand_addr(); ld_wdata = 8'($urandom);
                end
                if (last_done[1]) begin
                    cpu_pend = 0; cpu_req = 0;
                end else if (cpu_pend && own == 2) begin
                    cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
                    cpu_we = 1'($urandom); cpu_wide = 1'($urandom); cpu_req = 1'($urandom);
                end else if (!cpu_pend && $urandom_range(0, 2) == 0) begin
                    cpu_pend = 1;
                    cpu_start(1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: cpu_req in 1 CPU access request, held until cpu_done; cpu_we in 1 write=1; cpu_wide in 1 16-bit access=1; cpu_addr in 16; cpu_wdata in 16.
REQ-004 SHALL have: ld_req in 1 loader request, held until ld_done; ld_addr in 16; ld_wdata in 8 (loader is byte-write only).
REQ-005 SHALL have: cpu_gnt, ld_gnt out 1 each, owner of current transaction; cpu_done, ld_done out 1 each, one-cycle completion pulse.
REQ-006 SHALL have: mem_out in 16 MDR value from memory; rd_data out 16 = mem_out, valid only while cpu_done=1.
REQ-007 SHALL have memory strobes out 1 each: mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl; bus_out out 16 value driven onto memory bus.
REQ-008 Parameter: none; address path 16 bits, memory decodes low 6 bits.

Function
REQ-009 FSM states SHALL be IDLE, ADDR, DATA, WR, RDH, RDL, DONE, plus a 1-bit phase flag (0=first byte, 1=second byte).
REQ-010 In IDLE with any request, SHALL grant, latch owner/we/wide/addr/wdata into internal registers, clear phase, go to ADDR next cycle.
REQ-011 Arbitration: single requester wins; both requesting -> requester not granted last SHALL win (round-robin); after reset loader has priority.
REQ-012 Loader transaction SHALL be forced we=1, wide=0, wdata={8'h00, ld_wdata}.
REQ-013 gnt of owner SHALL be 1 from ADDR through DONE inclusive; 0 in IDLE.
REQ-014 ADDR: mar_loadh=mar_loadl=1, bus_out=latched address (phase=1: address+1, mod 2^16).
REQ-015 Byte read: ADDR -> RDL (ram_enl=1) -> DONE.
REQ-016 Wide read: ADDR -> RDH (ram_enh=1) -> ADDR(phase=1) -> RDL -> DONE; mem_out[15:8]=byte at addr, [7:0]=byte at addr+1.
REQ-017 Byte write: ADDR -> DATA (mdr_load=1, bus_out={8'h00,wdata[7:0]}) -> WR (ram_load=1) -> DONE.
REQ-018 Wide write: ADDR -> DATA(bus_out={8'h00,wdata[15:8]}) -> WR -> ADDR(phase=1) -> DATA(bus_out={8'h00,wdata[7:0]}) -> WR -> DONE; big-endian, high byte at addr.
REQ-019 DONE: owner's done=1 for exactly one cycle, next state IDLE; new grant possible in the following IDLE cycle.
REQ-020 All strobes and bus_out SHALL be Moore outputs decoded from state; at most one of ram_enh/ram_enl/ram_load/mdr_load high per cycle; bus_out=0 outside ADDR/DATA.
REQ-021 Latency from grant cycle (IDLE) to done: byte read 3, byte write 4, wide read 5, wide write 7 cycles.
REQ-022 Request inputs and addr/wdata changes after grant SHALL be ignored until DONE; deasserted req mid-transaction SHALL NOT abort it.
REQ-023 Address 16'hFFFF wide access SHALL wrap second byte to 16'h0000.
REQ-024 SHALL never assert call/ret-style stack access; stack traffic is outside this block.

Reset
REQ-025 rst=1 SHALL force IDLE, phase=0, round-robin pointer to loader-priority, all gnt/done/strobes=0, bus_out=0, on that edge regardless of state.
REQ-026 Reset mid-transaction SHALL abort it with no done pulse; partial writes already issued are not undone.
REQ-027 rst dominates simultaneous requests; first grant earliest on cycle after rst deasserts.

Verification
REQ-028 Loader byte write ld_addr=0x0005, ld_wdata=0xA5 -> ADDR bus_out=0x0005, DATA bus_out=0x00A5, WR ram_load=1, ld_done at cycle 4.
REQ-029 CPU wide write addr=0x0010, wdata=0x1234, then wide read 0x0010 -> rd_data=0x1234 with cpu_done, read latency 5.
REQ-030 cpu_req and ld_req both held from reset release -> grants ld, cpu, ld, cpu alternating; no cycle with both gnt=1.
REQ-031 Wide read at 0xFFFF -> second ADDR bus_out=0x0000.
REQ-032 rst asserted in WR of wide write -> next cycle IDLE, all outputs 0, no done pulse; fresh request then completes normally.
REQ-033 Every cycle check: strobe one-hot-or-zero rule (REQ-020) and gnt mutual exclusion.
